// File: rtl/ham_enc_arbiter.sv
// Two-requester round-robin front end for a shared combinational Hamming(7,4)
// encoder: each accepted byte becomes two registered codewords, one per nibble.
module ham_enc_arbiter #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0_valid,
    input  logic [7:0] in0_data,
    output logic       in0_ready,
    input  logic       in1_valid,
    input  logic [7:0] in1_data,
    output logic       in1_ready,
    output logic [3:0] enc_data,
    input  logic [6:0] enc_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_code,
    output logic       out_src,
    output logic       out_last
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;

    logic [1:0] state_reg;
    logic       rr_reg;
    logic [7:0] byte_reg;
    logic       src_reg;
    logic       out_valid_reg;
    logic [6:0] out_code_reg;
    logic       out_src_reg;
    logic       out_last_reg;

    logic       idle;
    logic       grant0;
    logic       grant1;
    logic       hs0;
    logic       hs1;
    logic       load;
    logic [3:0] first_nib;
    logic [3:0] second_nib;

    assign idle   = (state_reg == IDLE);
    // rr_reg only breaks ties; a lone valid requester always wins.
    assign grant0 = in0_valid & (~in1_valid | ~rr_reg);
    assign grant1 = in1_valid & (~in0_valid |  rr_reg);

    assign in0_ready = rst_n & idle & grant0;
    assign in1_ready = rst_n & idle & grant1;
    assign hs0       = in0_valid & in0_ready;
    assign hs1       = in1_valid & in1_ready;

    assign first_nib  = (LSB_FIRST != 0) ? byte_reg[3:0] : byte_reg[7:4];
    assign second_nib = (LSB_FIRST != 0) ? byte_reg[7:4] : byte_reg[3:0];

    always_comb begin
        enc_data = 4'h0;
        if (rst_n) begin
            case (state_reg)
                FIRST:   enc_data = first_nib;
                SECOND:  enc_data = second_nib;
                default: enc_data = 4'h0;
            endcase
        end
    end

    // A codeword loads whenever the output register is empty or being drained.
    assign load = ~idle & (~out_valid_reg | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            byte_reg  <= 8'h00;
            src_reg   <= 1'b0;
        end else if (hs0) begin
            byte_reg  <= in0_data;
            src_reg   <= 1'b0;
            rr_reg    <= 1'b1;
            state_reg <= FIRST;
        end else if (hs1) begin
            byte_reg  <= in1_data;
            src_reg   <= 1'b1;
            rr_reg    <= 1'b0;
            state_reg <= FIRST;
        end else if (load) begin
            state_reg <= (state_reg == FIRST) ? SECOND : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_code_reg  <= 7'h00;
            out_src_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_code_reg  <= enc_code;
            out_src_reg   <= src_reg;
            out_last_reg  <= (state_reg == SECOND);
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_code  = out_code_reg;
    assign out_src   = out_src_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_ham_enc_arbiter.sv
// Bench for ham_enc_arbiter: reference Hamming(7,4) encoder feeding the DUT,
// scoreboard of expected codewords, and directed/random scenario tasks.
module tb_ham_enc_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in1_valid;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready;
    logic [3:0] enc_data;
    logic [6:0] enc_code;
    logic       out_valid, out_ready;
    logic [6:0] out_code;
    logic       out_src, out_last;

    logic       m_in0_valid, m_in1_valid;
    logic [7:0] m_in0_data, m_in1_data;
    logic       m_in0_ready, m_in1_ready;
    logic [3:0] m_enc_data;
    logic [6:0] m_enc_code;
    logic       m_out_valid, m_out_ready;
    logic [6:0] m_out_code;
    logic       m_out_src, m_out_last;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] code;
        logic       src;
        logic       last;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Positions 1..7 = p1 p2 d0 p4 d1 d2 d3, position 1 in bit 0.
    function automatic logic [6:0] ham(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    assign enc_code   = ham(enc_data);
    assign m_enc_code = ham(m_enc_data);

    ham_enc_arbiter #(.LSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .enc_data(enc_data), .enc_code(enc_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_src(out_src), .out_last(out_last)
    );

    ham_enc_arbiter #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(m_in0_valid), .in0_data(m_in0_data), .in0_ready(m_in0_ready),
        .in1_valid(m_in1_valid), .in1_data(m_in1_data), .in1_ready(m_in1_ready),
        .enc_data(m_enc_data), .enc_code(m_enc_code),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_code(m_out_code), .out_src(m_out_src), .out_last(m_out_last)
    );

    task automatic push_byte(input logic [7:0] d, input logic s);
        exp_t e;
        e.code = ham(d[3:0]); e.src = s; e.last = 1'b0;
        sb.push_back(e);
        e.code = ham(d[7:4]); e.src = s; e.last = 1'b1;
        sb.push_back(e);
    endtask

    // Monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (in0_ready && in1_ready) begin
                errors++;
                $display("FAIL ready_onehot: in0_ready=%b in1_ready=%b, required at most one", in0_ready, in1_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got code=%h src=%b last=%b, required no codeword", out_code, out_src, out_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_code, out_src, out_last} !== {e.code, e.src, e.last}) begin
                        errors++;
                        $display("FAIL sb_codeword: got code=%h src=%b last=%b, required code=%h src=%b last=%b",
                                 out_code, out_src, out_last, e.code, e.src, e.last);
                    end else
                        $display("codeword %h src=%b last=%b ok", out_code, out_src, out_last);
                end
            end
            if (in0_valid && in0_ready) push_byte(in0_data, 1'b0);
            if (in1_valid && in1_ready) push_byte(in1_data, 1'b1);
        end
    end

    task automatic wait_hs(output int src, output bit ok);
        ok = 1'b0;
        src = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in0_valid && in0_ready) begin src = 0; ok = 1'b1; break; end
            if (in1_valid && in1_ready) begin src = 1; ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in0_valid = 1'b1; in0_data = 8'hB5;
        in1_valid = 1'b1; in1_data = 8'h11;
        out_ready = 1'b1;
        #2;
        checks++;
        if ({in0_ready, in1_ready, enc_data, out_valid, out_code, out_src, out_last} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy0=%b rdy1=%b enc=%h ov=%b code=%h src=%b last=%b, required all zero",
                     in0_ready, in1_ready, enc_data, out_valid, out_code, out_src, out_last);
        end else
            $display("reset outputs ok");
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || enc_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: got ov=%b enc=%h, required 0 and 0", out_valid, enc_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int s; bit ok;
        in0_data = 8'hB5; in0_valid = 1'b1; out_ready = 1'b1;
        wait_hs(s, ok);
        checks++;
        if (!ok || s != 0) begin errors++; $display("FAIL single_grant: got src=%0d, required 0", s); end
        @(posedge clk); #1 in0_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_code, out_src, out_last} !== {1'b1, 7'h2D, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_first: got ov=%b code=%h src=%b last=%b, required 1 2d 0 0", out_valid, out_code, out_src, out_last);
        end else $display("single first codeword ok");
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_code, out_src, out_last} !== {1'b1, 7'h55, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_second: got ov=%b code=%h src=%b last=%b, required 1 55 0 1", out_valid, out_code, out_src, out_last);
        end else $display("single second codeword ok");
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done: got ov=%b, required 0", out_valid); end
    endtask

    task automatic test_contention();
        int s0, s1; bit ok0, ok1;
        in0_data = 8'h0F; in1_data = 8'hAF; out_ready = 1'b1;
        rst_n = 1'b0; sb.delete();
        in0_valid = 1'b1; in1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL contention_pref: got rdy0=%b rdy1=%b, required 1 0", in0_ready, in1_ready);
        end
        wait_hs(s0, ok0);
        @(posedge clk); #1;
        wait_hs(s1, ok1);
        @(posedge clk); #1 in0_valid = 1'b0; in1_valid = 1'b0;
        checks++;
        if (!ok0 || !ok1 || s0 != 0 || s1 != 1) begin
            errors++;
            $display("FAIL contention_order: got %0d then %0d, required 0 then 1", s0, s1);
        end else $display("contention order in0 then in1 ok");
        repeat (4) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL contention_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        in0_data = 8'hB5; in0_valid = 1'b1;
        in1_data = 8'h77; in1_valid = 1'b1; out_ready = 1'b1;
        wait_hs(s, ok);
        checks++;
        if (!ok || s != 0) begin errors++; $display("FAIL bp_grant: got src=%0d, required 0", s); end
        @(posedge clk); #1 in0_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_code, out_last, in0_ready, in1_ready, enc_data} !== {1'b1, 7'h2D, 1'b0, 1'b0, 1'b0, 4'hB}) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got ov=%b code=%h last=%b rdy0=%b rdy1=%b enc=%h, required 1 2d 0 0 0 b",
                         i, out_valid, out_code, out_last, in0_ready, in1_ready, enc_data);
            end else $display("backpressure hold cycle %0d ok", i);
            in1_data = 8'($urandom);
        end
        in1_data = 8'h3C; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_code, out_last} !== {1'b1, 7'h55, 1'b1}) begin
            errors++;
            $display("FAIL bp_release: got ov=%b code=%h last=%b, required 1 55 1", out_valid, out_code, out_last);
        end
        wait_hs(s, ok);
        checks++;
        if (!ok || s != 1) begin errors++; $display("FAIL bp_next_grant: got src=%0d, required 1", s); end
        @(posedge clk); #1 in1_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_msb_first();
        bit ok;
        ok = 1'b0;
        m_in0_data = 8'hB5; m_in0_valid = 1'b1; m_out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_in0_valid && m_in0_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 m_in0_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL msb_grant: got no handshake, required one"); end
        @(posedge clk); #1;
        checks++;
        if ({m_out_valid, m_out_code, m_out_last} !== {1'b1, 7'h55, 1'b0}) begin
            errors++;
            $display("FAIL msb_first: got ov=%b code=%h last=%b, required 1 55 0", m_out_valid, m_out_code, m_out_last);
        end else $display("msb-first codeword 55 ok");
        @(posedge clk); #1;
        checks++;
        if ({m_out_valid, m_out_code, m_out_last} !== {1'b1, 7'h2D, 1'b1}) begin
            errors++;
            $display("FAIL msb_second: got ov=%b code=%h last=%b, required 1 2d 1", m_out_valid, m_out_code, m_out_last);
        end else $display("msb-first codeword 2d ok");
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        in0_data = 8'hB5; in0_valid = 1'b1; in1_valid = 1'b0; out_ready = 1'b1;
        wait_hs(s, ok);
        @(posedge clk); #1 in0_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup: got ov=%b, required 1", out_valid); end
        #2 rst_n = 1'b0; sb.delete();
        #1;
        checks++;
        if ({out_valid, enc_data, out_code} !== 12'h0) begin
            errors++;
            $display("FAIL rmid_async: got ov=%b enc=%h code=%h, required 0 0 00", out_valid, enc_data, out_code);
        end else $display("async reset mid-byte ok");
        @(posedge clk); #1 rst_n = 1'b1;
        in1_data = 8'h5A; in1_valid = 1'b1;
        #1;
        checks++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in1_alone: got rdy0=%b rdy1=%b, required 0 1", in0_ready, in1_ready);
        end
        in0_data = 8'hC3; in0_valid = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pref0: got rdy0=%b rdy1=%b, required 1 0", in0_ready, in1_ready);
        end
        #1 in1_valid = 1'b0; out_ready = 1'b1;
        wait_hs(s, ok);
        @(posedge clk); #1 in0_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (!ok || s != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rmid_after: got src=%0d pending=%0d, required 0 and 0", s, sb.size());
        end
    endtask

    task automatic test_sustained();
        int nbytes = 0;
        int last_src = -1;
        bit hs0, hs1;
        in0_data = 8'($urandom); in1_data = 8'($urandom);
        in0_valid = 1'b1; in1_valid = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            hs0 = in0_valid && in0_ready;
            hs1 = in1_valid && in1_ready;
            if (hs0 || hs1) begin
                checks++;
                if (last_src == (hs1 ? 1 : 0)) begin
                    errors++;
                    $display("FAIL sustained_alternate: byte %0d got src=%0d twice, required alternation", nbytes, last_src);
                end
                last_src = hs1 ? 1 : 0;
                nbytes++;
            end
            @(posedge clk); #1;
            if (hs0) in0_data = 8'($urandom);
            if (hs1) in1_data = 8'($urandom);
            out_ready = 1'($urandom);
            if (nbytes >= 1000) break;
        end
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (nbytes < 1000) begin errors++; $display("FAIL sustained_timeout: got %0d bytes, required 1000", nbytes); end
        repeat (6) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sustained_drain: got pending=%0d ov=%b, required 0 and 0", sb.size(), out_valid);
        end else $display("sustained traffic: %0d bytes ok", nbytes);
    endtask

    initial begin
        m_in0_valid = 1'b0; m_in0_data = 8'h00;
        m_in1_valid = 1'b0; m_in1_data = 8'h00;
        m_out_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_msb_first();
        test_reset_mid();
        test_sustained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
